// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and constants for param_sync_ram
// Purpose : clear-sequencer state encoding and read-during-write mode constants.
// Ports   : none (package).
package ram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/ram_clear_seq.sv
// rtl/ram_clear_seq.sv - zero-fill sequencer for param_sync_ram
// Purpose : walks a pointer over every word after reset or on request,
//           issuing one zero write per cycle.
// Ports   : clk, rst (sync, active-high), clr_req (start request, IDLE only),
//           busy (CLEAR state), clr_we (clear write strobe), clr_addr (clear pointer).
import ram_pkg::*;

module ram_clear_seq #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(DEPTH - 1);

  clr_state_t        r_state;
  clr_state_t        w_next_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_next_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_next_state;
      r_ptr   <= w_next_ptr;
    end
  end

  // clr_req during CLEAR is deliberately not looked at: no restart, no extension.
  always_comb begin
    w_next_state = r_state;
    w_next_ptr   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (clr_req) begin
          w_next_state = ST_CLEAR;
          w_next_ptr   = '0;
        end
      end
      ST_CLEAR: begin
        if (r_ptr == LP_LAST) begin
          w_next_state = ST_IDLE;
          w_next_ptr   = '0;
        end else begin
          w_next_ptr = r_ptr + 1'b1;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_ptr   = '0;
      end
    endcase
  end

  assign busy     = (r_state == ST_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = r_ptr;

endmodule

// File: rtl/param_sync_ram.sv
// rtl/param_sync_ram.sv - parametrised simple-dual-port synchronous RAM
// Purpose : one write port with byte enables, one registered read port with a
//           valid strobe, selectable read-during-write behaviour, built-in zero-fill.
// Ports   : clk, rst (sync, active-high), clr_req (start zero-fill),
//           wr_en/wr_addr/data/be (write port), rd_en/rd_addr (read request),
//           q/q_valid (registered read result), busy (zero-fill in progress).
import ram_pkg::*;

module param_sync_ram #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int DEPTH    = 64,
  parameter int RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_req,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   data,
  input  logic [DATA_W/8-1:0] be,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   q,
  output logic                q_valid,
  output logic                busy
);

  localparam int              LP_LANES = DATA_W / 8;
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [DATA_W-1:0] r_q;
  logic              r_q_valid;

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_wr_in_range;
  logic              w_rd_in_range;
  logic [ADDR_W-1:0] w_wr_idx;
  logic [ADDR_W-1:0] w_rd_idx;
  logic [DATA_W-1:0] w_wr_old;
  logic [DATA_W-1:0] w_rd_old;
  logic [DATA_W-1:0] w_wr_merged;
  logic              w_user_we;
  logic              w_rd_accept;
  logic              w_rdw_hit;

  ram_clear_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (w_busy),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  assign w_wr_in_range = ({1'b0, wr_addr} < LP_DEPTH);
  assign w_rd_in_range = ({1'b0, rd_addr} < LP_DEPTH);

  // Out-of-range addresses are steered to word 0 so the array is never indexed past its end.
  assign w_wr_idx = w_wr_in_range ? wr_addr : '0;
  assign w_rd_idx = w_rd_in_range ? rd_addr : '0;
  assign w_wr_old = r_mem[w_wr_idx];
  assign w_rd_old = r_mem[w_rd_idx];

  always_comb begin
    w_wr_merged = w_wr_old;
    for (int i = 0; i < LP_LANES; i++) begin
      if (be[i]) begin
        w_wr_merged[8*i +: 8] = data[8*i +: 8];
      end
    end
  end

  assign w_user_we   = !w_busy && wr_en && w_wr_in_range;
  assign w_rd_accept = !w_busy && rd_en;
  assign w_rdw_hit   = w_user_we && (wr_addr == rd_addr);

  // Single write process so the array maps onto a RAM macro; nothing is written during rst.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_clr_we) begin
        r_mem[w_clr_addr] <= '0;
      end else if (w_user_we) begin
        r_mem[w_wr_idx] <= w_wr_merged;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q       <= '0;
      r_q_valid <= 1'b0;
    end else if (w_rd_accept) begin
      r_q_valid <= 1'b1;
      if (!w_rd_in_range) begin
        r_q <= '0;
      end else if ((RDW_MODE == RDW_NEW) && w_rdw_hit) begin
        r_q <= w_wr_merged;
      end else begin
        r_q <= w_rd_old;
      end
    end else begin
      r_q_valid <= 1'b0;
    end
  end

  assign q       = r_q;
  assign q_valid = r_q_valid;
  assign busy    = w_busy;

endmodule

// File: tb/tb_param_sync_ram.sv
// tb/tb_param_sync_ram.sv - self-checking bench for param_sync_ram
module tb_param_sync_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr_req = 1'b0;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [15:0] data = '0;
  logic [1:0]  be = '0;
  logic        rd_en = 1'b0;
  logic [5:0]  rd_addr = '0;

  logic [15:0] q0, q1;
  logic        v0, v1, busy0, busy1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // dut0: full depth, old-data read-during-write
  param_sync_ram #(.DATA_W(16), .ADDR_W(6), .DEPTH(64), .RDW_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .wr_en(wr_en), .wr_addr(wr_addr),
    .data(data), .be(be), .rd_en(rd_en), .rd_addr(rd_addr),
    .q(q0), .q_valid(v0), .busy(busy0)
  );

  // dut1: partial depth, write-through read-during-write
  param_sync_ram #(.DATA_W(16), .ADDR_W(6), .DEPTH(48), .RDW_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .wr_en(wr_en), .wr_addr(wr_addr),
    .data(data), .be(be), .rd_en(rd_en), .rd_addr(rd_addr),
    .q(q1), .q_valid(v1), .busy(busy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per instance, a word array, remaining busy cycles and expected q/q_valid.
  int          dep [2] = '{64, 48};
  int          rdw [2] = '{0, 1};
  logic [15:0] mm  [2][64];
  int          bc  [2];
  logic [15:0] mq  [2];
  logic        mv  [2];
  bit          started = 1'b0;
  logic [15:0] m_old, m_new;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        bc[i] = dep[i];
        mq[i] = '0;
        mv[i] = 1'b0;
        for (int j = 0; j < 64; j++) mm[i][j] = '0;
      end else if (bc[i] > 0) begin
        bc[i] = bc[i] - 1;
        mv[i] = 1'b0;
      end else begin
        m_old = (int'(wr_addr) < dep[i]) ? mm[i][wr_addr] : 16'h0;
        m_new = m_old;
        if (be[0]) m_new[7:0]  = data[7:0];
        if (be[1]) m_new[15:8] = data[15:8];
        if (rd_en) begin
          mv[i] = 1'b1;
          if (int'(rd_addr) >= dep[i])                      mq[i] = '0;
          else if (rdw[i] == 1 && wr_en && wr_addr == rd_addr
                   && int'(wr_addr) < dep[i])              mq[i] = m_new;
          else                                              mq[i] = mm[i][rd_addr];
        end else begin
          mv[i] = 1'b0;
        end
        if (wr_en && int'(wr_addr) < dep[i]) mm[i][wr_addr] = m_new;
        if (clr_req) begin
          bc[i] = dep[i];
          for (int j = 0; j < 64; j++) mm[i][j] = '0;
        end
      end
    end
    if (rst) started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("busy0", 32'(busy0), 32'(bc[0] > 0));
      chk("busy1", 32'(busy1), 32'(bc[1] > 0));
      chk("q_valid0", 32'(v0), 32'(mv[0]));
      chk("q_valid1", 32'(v1), 32'(mv[1]));
      chk("q0", 32'(q0), 32'(mq[0]));
      chk("q1", 32'(q1), 32'(mq[1]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_req = 1'b0;
    be      = '0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d, input logic [1:0] b);
    wr_en = 1'b1; wr_addr = a; data = d; be = b;
  endtask

  task automatic rd(input logic [5:0] a);
    rd_en = 1'b1; rd_addr = a;
  endtask

  task automatic count_busy(output int n0, output int n1);
    n0 = 0; n1 = 0;
    for (int k = 0; k < 100; k++) begin
      if (busy0) n0++;
      if (busy1) n1++;
      step();
    end
  endtask

  int n0, n1;

  initial begin
    // 1: reset, clear length, cleared contents
    rst = 1'b1; step(); step();
    chk("rst_q0", 32'(q0), 32'h0);
    chk("rst_v0", 32'(v0), 32'h0);
    chk("rst_busy0", 32'(busy0), 32'h1);
    rst = 1'b0;
    count_busy(n0, n1);
    chk("clear_len0", n0, 64);
    chk("clear_len1", n1, 48);
    rd(6'd0);  step(); chk("t1_q_a0", 32'(q0), 32'h0); chk("t1_v_a0", 32'(v0), 32'h1);
    rd(6'd1);  step(); chk("t1_q_a1", 32'(q0), 32'h0); chk("t1_v_a1", 32'(v0), 32'h1);
    rd(6'd63); step(); chk("t1_q_a63", 32'(q0), 32'h0); chk("t1_v_a63", 32'(v0), 32'h1);
    step(); chk("t1_v_drop", 32'(v0), 32'h0);

    // 2: byte-lane merge
    wr(6'd5, 16'hA55A, 2'b11); step();
    wr(6'd5, 16'h1234, 2'b01); step();
    rd(6'd5); step();
    chk("t2_q0", 32'(q0), 32'hA534);
    chk("t2_q1", 32'(q1), 32'hA534);
    wr(6'd5, 16'hFFFF, 2'b00); step();
    rd(6'd5); step();
    chk("t2_be0_noop", 32'(q0), 32'hA534);

    // 3: back-to-back
    wr(6'd0, 16'd55, 2'b11);  step();
    wr(6'd1, 16'd100, 2'b11); step();
    wr(6'd2, 16'd200, 2'b11); step();
    rd(6'd0); step(); chk("t3_q0", 32'(q0), 32'd55);  chk("t3_v0", 32'(v0), 32'h1);
    rd(6'd1); step(); chk("t3_q1", 32'(q0), 32'd100); chk("t3_v1", 32'(v0), 32'h1);
    rd(6'd2); step(); chk("t3_q2", 32'(q0), 32'd200); chk("t3_v2", 32'(v0), 32'h1);

    // 4: read-during-write
    wr(6'd7, 16'h0011, 2'b11); step();
    wr(6'd7, 16'h0022, 2'b11); rd(6'd7); step();
    chk("t4_old", 32'(q0), 32'h11);
    chk("t4_new", 32'(q1), 32'h22);
    rd(6'd7); step();
    chk("t4_after0", 32'(q0), 32'h22);
    chk("t4_after1", 32'(q1), 32'h22);

    // 5: clear on request, writes and re-request ignored while busy
    wr(6'd9, 16'h00FF, 2'b11); step();
    clr_req = 1'b1; step();
    n0 = 0;
    for (int k = 0; k < 100; k++) begin
      if (busy0) begin
        n0++;
        wr(6'd9, 16'h0077, 2'b11);
        if (k == 20) clr_req = 1'b1;
      end
      step();
    end
    chk("t5_len", n0, 64);
    rd(6'd9); step();
    chk("t5_q", 32'(q0), 32'h0);

    // 6: reset mid-clear restarts; out-of-range on the partial-depth instance
    clr_req = 1'b1; step();
    repeat (30) step();
    rst = 1'b1; step(); rst = 1'b0;
    count_busy(n0, n1);
    chk("t6_len0", n0, 64);
    chk("t6_len1", n1, 48);
    wr(6'd50, 16'hBEEF, 2'b11); step();
    rd(6'd50); step();
    chk("t6_oor_q1", 32'(q1), 32'h0);
    chk("t6_oor_v1", 32'(v1), 32'h1);
    chk("t6_inr_q0", 32'(q0), 32'hBEEF);

    // random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rst     = ($urandom_range(0, 999) == 0);
      clr_req = ($urandom_range(0, 199) == 0);
      wr_en   = $urandom_range(0, 1);
      wr_addr = 6'($urandom_range(0, 63));
      data    = 16'($urandom);
      be      = 2'($urandom_range(0, 3));
      rd_en   = $urandom_range(0, 1);
      rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 6'($urandom_range(0, 63));
      step();
    end
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
